branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_if.sv | 26 ++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, branch update and statistics signals of the branch predictor
interface branch_predictor_if #(
   parameter int CNT_BITS = 16
);
   logic                fetch_valid;
   logic [31:0]         fetch_pc;
   logic                pred_valid;
   logic                pred_taken;
   logic                upd_valid;
   logic [31:0]         upd_pc;
   logic                upd_taken;
   logic                upd_pred;
   logic                mispredict;
   logic [CNT_BITS-1:0] branch_count;
   logic [CNT_BITS-1:0] mispredict_count;

   modport master (
      output fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_pred,
      input  pred_valid, pred_taken, mispredict, branch_count, mispredict_count
   );

   modport slave (
      input  fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_pred,
      output pred_valid, pred_taken, mispredict, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating counter predictor; define BRANCH_PREDICTOR_GSHARE_EN for gshare indexing
module branch_predictor #(
   parameter int INDEX_BITS = 4,
   parameter int CNT_BITS   = 16
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bp
);
   localparam int         ENTRIES = 1 << INDEX_BITS;
   localparam logic [1:0] WEAK_NT = 2'b01;

   logic [1:0]            table_q [ENTRIES];
   logic [1:0]            table_d [ENTRIES];
   logic                  pred_valid_q, pred_valid_d;
   logic                  pred_taken_q, pred_taken_d;
   logic                  mispredict_q, mispredict_d;
   logic [CNT_BITS-1:0]   branch_count_q, branch_count_d;
   logic [CNT_BITS-1:0]   mispredict_count_q, mispredict_count_d;
   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic                  upd_miss;

   // PC bits outside the index field never influence the table
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.fetch_pc[31:INDEX_BITS+2], bp.fetch_pc[1:0],
                             bp.upd_pc[31:INDEX_BITS+2], bp.upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [INDEX_BITS-1:0] ghr_q, ghr_d;

   // lookup and update both hash with the history as it stands this cycle
   assign fetch_idx = bp.fetch_pc[INDEX_BITS+1:2] ^ ghr_q;
   assign upd_idx   = bp.upd_pc[INDEX_BITS+1:2] ^ ghr_q;

   // resolved direction shifts into history only on a retired branch
   always_comb begin
      ghr_d = ghr_q;
      if (bp.upd_valid) begin
         ghr_d = {ghr_q[INDEX_BITS-2:0], bp.upd_taken};
      end
   end

   // history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end
`else
   assign fetch_idx = bp.fetch_pc[INDEX_BITS+1:2];
   assign upd_idx   = bp.upd_pc[INDEX_BITS+1:2];
`endif

   assign upd_miss = bp.upd_valid && (bp.upd_taken != bp.upd_pred);

   // lookup reads the pre-update table; update steps the counter and statistics
   always_comb begin
      pred_valid_d       = bp.fetch_valid;
      pred_taken_d       = pred_taken_q;
      mispredict_d       = upd_miss;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      table_d            = table_q;
      if (bp.fetch_valid) begin
         pred_taken_d = table_q[fetch_idx][1];
      end
      if (bp.upd_valid) begin
         if (branch_count_q != '1) begin
            branch_count_d = branch_count_q + CNT_BITS'(1);
         end
         if (upd_miss && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + CNT_BITS'(1);
         end
         if (bp.upd_taken) begin
            if (table_q[upd_idx] != 2'b11) begin
               table_d[upd_idx] = table_q[upd_idx] + 2'd1;
            end
         end else begin
            if (table_q[upd_idx] != 2'b00) begin
               table_d[upd_idx] = table_q[upd_idx] - 2'd1;
            end
         end
      end
   end

   // pattern table, registered outputs and statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= WEAK_NT;
         end
         pred_valid_q       <= 1'b0;
         pred_taken_q       <= 1'b0;
         mispredict_q       <= 1'b0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         table_q            <= table_d;
         pred_valid_q       <= pred_valid_d;
         pred_taken_q       <= pred_taken_d;
         mispredict_q       <= mispredict_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign bp.pred_valid       = pred_valid_q;
   assign bp.pred_taken       = pred_taken_q;
   assign bp.mispredict       = mispredict_q;
   assign bp.branch_count     = branch_count_q;
   assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a table model
module tb_branch_predictor;
   localparam int IB      = 4;
   localparam int CNT     = 4;
   localparam int ENTRIES = 1 << IB;
   localparam int CMAX    = (1 << CNT) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   int   m_tbl [ENTRIES];
   int   m_ghr;
   int   m_bc;
   int   m_mc;
   logic exp_pv;
   logic exp_pt;
   logic exp_mp;

   branch_predictor_if #(.CNT_BITS(CNT)) bp ();

   branch_predictor #(.INDEX_BITS(IB), .CNT_BITS(CNT)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      int idx;
      idx = int'((pc / 4) % ENTRIES);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      idx = idx ^ m_ghr;
`endif
      return idx;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
      m_ghr  = 0;
      m_bc   = 0;
      m_mc   = 0;
      exp_pv = 1'b0;
      exp_pt = 1'b0;
      exp_mp = 1'b0;
   endtask

   task automatic check_outputs();
      check("pred_valid", {31'd0, bp.pred_valid}, {31'd0, exp_pv});
      check("pred_taken", {31'd0, bp.pred_taken}, {31'd0, exp_pt});
      check("mispredict", {31'd0, bp.mispredict}, {31'd0, exp_mp});
      check("branch_count", 32'(bp.branch_count), 32'(m_bc));
      check("mispredict_count", 32'(bp.mispredict_count), 32'(m_mc));
   endtask

   // one clock: drive inputs, advance the model, then compare after the edge
   task automatic step(input logic fv, input logic [31:0] fpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic up);
      int fi;
      int ui;
      bp.fetch_valid = fv;
      bp.fetch_pc    = fv ? fpc : 32'bx;
      bp.upd_valid   = uv;
      bp.upd_pc      = uv ? upc : 32'bx;
      bp.upd_taken   = ut;
      bp.upd_pred    = up;
      exp_pv = fv;
      if (fv) begin
         fi     = idx_of(fpc);
         exp_pt = (m_tbl[fi] >= 2);
      end
      exp_mp = uv && (ut != up);
      if (uv) begin
         ui = idx_of(upc);
         if (m_bc < CMAX) m_bc++;
         if (exp_mp && m_mc < CMAX) m_mc++;
         if (ut) m_tbl[ui] = (m_tbl[ui] == 3) ? 3 : m_tbl[ui] + 1;
         else    m_tbl[ui] = (m_tbl[ui] == 0) ? 0 : m_tbl[ui] - 1;
         m_ghr = ((m_ghr * 2) + int'(ut)) % ENTRIES;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // asynchronous reset asserted mid-cycle while traffic is still driven
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      bp.fetch_valid = 1'b0;
      bp.upd_valid   = 1'b0;
      rst            = 1'b0;
   endtask

   initial begin
      logic [31:0] fpc;
      logic [31:0] upc;
      bp.fetch_valid = 1'b0;
      bp.fetch_pc    = '0;
      bp.upd_valid   = 1'b0;
      bp.upd_pc      = '0;
      bp.upd_taken   = 1'b0;
      bp.upd_pred    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // first lookup after reset predicts not-taken
      step(1, 32'h100, 0, 0, 0, 0);
      check("first_pred", {31'd0, bp.pred_taken}, 32'd0);
      step(0, 0, 0, 0, 0, 0);
      check("idle_pred_valid", {31'd0, bp.pred_valid}, 32'd0);

      // three mispredicted taken updates saturate entry 0
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 32'h100, 1, 0);
         check("mp_pulse", {31'd0, bp.mispredict}, 32'd1);
      end
      check("mp_count3", 32'(bp.mispredict_count), 32'd3);
      step(1, 32'h100, 0, 0, 0, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("trained_pred", {31'd0, bp.pred_taken}, 32'd1);
`endif
      step(0, 0, 0, 0, 0, 0);
      check("mp_low", {31'd0, bp.mispredict}, 32'd0);

      // same-cycle lookup and update read the pre-update value
      do_reset();
      step(1, 32'h104, 1, 32'h104, 1, 1);
      check("rbw_pred", {31'd0, bp.pred_taken}, 32'd0);
      step(1, 32'h104, 0, 0, 0, 0);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      check("rbw_later", {31'd0, bp.pred_taken}, 32'd1);
`endif

`ifdef BRANCH_PREDICTOR_GSHARE_EN
      // history 3 steers the 0x100 lookup to an untrained entry
      do_reset();
      step(0, 0, 1, 32'h100, 1, 1);
      step(0, 0, 1, 32'h100, 1, 1);
      step(1, 32'h100, 0, 0, 0, 0);
      check("gshare_idx3", {31'd0, bp.pred_taken}, 32'd0);
`endif

      // statistics counters saturate
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 1, 32'($urandom), 1'(i), 1'(~i));
      check("bc_sat", 32'(bp.branch_count), CMAX);
      check("mc_sat", 32'(bp.mispredict_count), CMAX);

      // reset with an update pending leaves no trace once released
      step(0, 0, 1, 32'h100, 1, 0);
      bp.upd_valid = 1'b1;
      bp.upd_pc    = 32'h100;
      bp.upd_taken = 1'b1;
      bp.upd_pred  = 1'b0;
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      check("no_pulse_after_rst", {31'd0, bp.mispredict}, 32'd0);
      for (int i = 0; i < ENTRIES; i++) begin
         step(1, 32'(i * 4), 0, 0, 0, 0);
      end

      // random traffic with frequent index collisions
      do_reset();
      for (int i = 0; i < 600; i++) begin
         fpc = $urandom;
         upc = ($urandom_range(0, 3) == 0) ? fpc : $urandom;
         step(1'($urandom_range(0, 1)), fpc, 1'($urandom_range(0, 1)), upc,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (i == 300) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
